// File: rtl/usr_shift_sequencer_pkg.sv
// Shared encodings for the universal shift register sequencer: register mode
// codes, sequencer states and shift-direction values.
package usr_shift_sequencer_pkg;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_UP   = 2'b01;
  localparam logic [1:0] SEL_DN   = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/usr_shift_sequencer.sv
// Sequences one parallel load followed by WIDTH shifts of a universal shift
// register per accepted word, streaming out the bits that leave the register.
module usr_shift_sequencer
  import usr_shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_fill,
  input  logic             abort,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] pi,
  output logic             sl_r,
  output logic             sl_l,
  input  logic [WIDTH-1:0] z_in,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        // abort has no meaning here, so a simultaneous request still goes through
        if (in_valid) begin
          data_d  = in_data;
          dir_d   = in_dir;
          fill_d  = in_fill;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything except ser_bit decodes from registered state only.
  always_comb begin
    sel       = SEL_HOLD;
    sl_r      = 1'b0;
    sl_l      = 1'b0;
    ser_valid = 1'b0;
    done      = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_LOAD:  sel = SEL_LOAD;
      ST_SHIFT: begin
        sel       = (dir_q == DIR_DN) ? SEL_DN : SEL_UP;
        sl_r      = (dir_q == DIR_UP) ? fill_q : 1'b0;
        sl_l      = (dir_q == DIR_DN) ? fill_q : 1'b0;
        ser_valid = 1'b1;
      end
      ST_DONE:  done = 1'b1;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  assign pi      = data_q;
  assign ser_bit = (dir_q == DIR_DN) ? z_in[0] : z_in[WIDTH-1];

  // Interior register bits are fed back but only the end bits ever leave.
  logic unused_z;
  assign unused_z = ^z_in;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Drives the sequencer into a behavioural universal shift register and checks
// streams, handshakes, abort and reset against a closed-form reference model.
module tb_usr_shift_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_dir, in_fill, abort;
  logic [W-1:0] in_data, pi, z;
  logic [1:0]   sel;
  logic         sl_r, sl_l, ser_bit, ser_valid, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  usr_shift_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .in_fill(in_fill), .abort(abort),
    .sel(sel), .pi(pi), .sl_r(sl_r), .sl_l(sl_l), .z_in(z),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  // Downstream 4-bit universal shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) z <= '0;
    else case (sel)
      2'b01:   z <= {z[W-2:0], sl_r};
      2'b10:   z <= {sl_l, z[W-1:1]};
      2'b11:   z <= pi;
      default: z <= z;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register contents after n shifts of word d in direction dr with fill fl.
  function automatic logic [31:0] z_after(input logic [W-1:0] d, input logic dr,
                                          input logic fl, input int n);
    int v;
    int fmask;
    fmask = fl ? ((1 << n) - 1) : 0;
    if (!dr) v = ((int'(d) << n) | fmask) & 15;
    else     v = (int'(d) >> n) | ((fmask << (W - n)) & 15);
    return v;
  endfunction

  function automatic logic exp_bit(input logic [W-1:0] d, input logic dr, input int k);
    return dr ? d[k] : d[W-1-k];
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("idle_timeout", in_ready, 1);
  endtask

  // One word from acceptance to completion; abort_at >= 0 aborts in that shift cycle.
  task automatic run_seq(input logic [W-1:0] d, input logic dr, input logic fl,
                         input int abort_at, input bit abort_on_accept);
    wait_idle();
    in_valid = 1'b1; in_data = d; in_dir = dr; in_fill = fl;
    abort = abort_on_accept;
    tick();
    in_valid = 1'b0; abort = 1'b0; in_data = ~d;
    check("load_sel", sel, 3);
    check("load_pi", pi, d);
    check("load_ready", in_ready, 0);
    tick();
    for (int k = 0; k < W; k++) begin
      check($sformatf("shift%0d_valid", k), ser_valid, 1);
      check($sformatf("shift%0d_bit", k), ser_bit, exp_bit(d, dr, k));
      check($sformatf("shift%0d_sel", k), sel, dr ? 2 : 1);
      check($sformatf("shift%0d_sl", k), {sl_l, sl_r}, dr ? {fl, 1'b0} : {1'b0, fl});
      check($sformatf("shift%0d_done", k), done, 0);
      if (k == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_sel", sel, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        check("abort_done", done, 0);
        check("abort_z", z, z_after(d, dr, fl, k + 1));
        tick();
        check("abort_z_hold", z, z_after(d, dr, fl, k + 1));
        check("abort_no_done", done, 0);
        return;
      end
      tick();
    end
    // Sixth edge counting the accept edge.
    check("done_pulse", done, 1);
    check("done_sel", sel, 0);
    check("done_ser_valid", ser_valid, 0);
    check("done_z", z, z_after(d, dr, fl, W));
    tick();
    check("done_width", done, 0);
    check("post_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] rd;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_fill = 1'b0; abort = 1'b0;
    #12;
    check("rst_sel", sel, 0);
    check("rst_pi", pi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_sl", {sl_l, sl_r}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_ready", in_ready, 1);

    run_seq(4'b1011, 1'b0, 1'b0, -1, 1'b0);
    run_seq(4'b1011, 1'b1, 1'b1, -1, 1'b0);

    // Request held high across two words.
    in_valid = 1'b1; in_data = 4'hA; in_dir = 1'b0; in_fill = 1'b1;
    tick();
    in_data = 4'h5;
    check("b2b_pi_a", pi, 4'hA);
    for (int i = 0; i < W + 1; i++) begin
      check("b2b_not_ready", in_ready, 0);
      tick();
    end
    check("b2b_done_a", done, 1);
    check("b2b_z_a", z, 4'hF);
    tick();
    check("b2b_ready_gap", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b_sel_b", sel, 3);
    check("b2b_pi_b", pi, 4'h5);
    for (int i = 0; i < W + 1; i++) tick();
    check("b2b_done_b", done, 1);
    check("b2b_z_b", z, 4'hF);
    tick();

    run_seq(4'b0110, 1'b0, 1'b1, 1, 1'b0);
    run_seq(4'b1001, 1'b1, 1'b0, 1, 1'b0);

    // Asynchronous reset in the middle of the shift phase.
    wait_idle();
    in_valid = 1'b1; in_data = 4'hC; in_dir = 1'b1; in_fill = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("mid_rst_sel", sel, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ser_valid", ser_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pi", pi, 0);
    check("mid_rst_z", z, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mid_rst_ready", in_ready, 1);
    run_seq(4'b1110, 1'b0, 1'b0, -1, 1'b0);

    run_seq(4'b0101, 1'b1, 1'b0, -1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rd = W'($urandom_range(0, 15));
      run_seq(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
